sr04_meas_scheduler: RTL and testbench
======================================

Name: sr04_meas_scheduler

Overview:
- Sequences the SR04 ultrasonic measurement path and shares it between two requesters: a manual one-shot request (debounced button) and a periodic auto-ranging timer.
- Issues single-cycle start pulses to the SR04 controller and enforces the sensor's minimum re-trigger gap.
- Supervises each measurement with a timeout, then latches and publishes the distance with a valid pulse or flags a timeout error.
- Sits between button/mode logic and the SR04 controller. Time base is the shared 1 us tick.

Parameters:
- MIN_GAP_US, 60000, minimum us from one sr04_start to the next; requires MIN_GAP_US > TIMEOUT_US.
- TIMEOUT_US, 30000, us after sr04_start with no meas_done before a timeout is declared.
- AUTO_PERIOD_US, 100000, auto request interval in us while auto_en=1.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-low
- tick_1us  in  1  one-clk pulse every 1 us
- req_manual  in  1  one-clk manual request pulse
- auto_en  in  1  level; enables periodic requests
- meas_done  in  1  one-clk pulse from the SR04 controller: echo measurement complete
- meas_dist  in  9  distance in cm; valid when meas_done=1
- sr04_start  out  1  one-clk start pulse to the SR04 controller
- dist_out  out  9  last successful distance in cm
- dist_valid  out  1  one-clk pulse when dist_out updates
- timeout_err  out  1  sticky; set on timeout, cleared on next successful measurement
- src_manual  out  1  requester of the current/last measurement (1=manual, 0=auto)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (rst=0): state=IDLE; all outputs 0; pending flags, auto timer and us counter cleared. Reset mid-measurement aborts immediately, with no sr04_start and no dist_valid afterwards.
- Pending flags:
  - man_pend is set by req_manual and cleared when served.
  - auto_pend is set when the auto timer expires and cleared when served.
  - Each flag is one deep; repeat requests while pending coalesce. Requests arriving while busy are recorded, not dropped.
- Auto timer (17 bit):
  - Counts tick_1us only while auto_en=1.
  - On a tick with value AUTO_PERIOD_US-1, it wraps to 0 and sets auto_pend.
  - auto_en=0 holds the timer at 0 and clears auto_pend.
- FSM states are IDLE, ISSUE, MEASURE, GAP.
  - IDLE: if man_pend, go to ISSUE with src_manual=1 and clear man_pend. Else if auto_pend, go to ISSUE with src_manual=0 and clear auto_pend. Manual has fixed priority; auto stays pending.
  - ISSUE (exactly 1 clk): sr04_start=1 (registered output, asserted the cycle after the IDLE decision); us counter cleared to 0; next state MEASURE.
  - MEASURE: us counter increments on tick_1us.
    - meas_done=1: dist_out<=meas_dist; dist_valid=1 the next cycle; timeout_err<=0; go to GAP.
    - Else, on a tick when the counter equals TIMEOUT_US-1: timeout_err<=1; dist_out unchanged; no dist_valid; go to GAP.
    - If meas_done and the timeout tick occur in the same cycle, meas_done wins.
  - GAP: us counter keeps counting ticks. On a tick where the counter equals MIN_GAP_US-1, go to IDLE. meas_done pulses here are ignored.
- Request-to-start latency: 2 clk from req_manual to sr04_start when idle (flag set, then IDLE decision, then ISSUE).
- Widths: us counter is 17 bit and saturates at its maximum value, never wraps. meas_dist is passed through unmodified.
- busy=1 in ISSUE, MEASURE and GAP.

Test Plan:
- Use MIN_GAP_US=20, TIMEOUT_US=10, AUTO_PERIOD_US=50 for all scenarios.
- Manual single shot: req_manual pulse at idle -> sr04_start one clk, 2 clk later; meas_done with meas_dist=9'd123 after 5 ticks -> dist_out=123, one dist_valid pulse, src_manual=1, busy low 20 ticks after sr04_start.
- Timeout: req_manual, no meas_done -> timeout_err=1 at tick 10; dist_out holds its previous value; no dist_valid. A following measurement with meas_dist=42 -> timeout_err=0, dist_out=42.
- Auto period: auto_en=1 held 200 ticks, meas_done after 3 ticks each time -> sr04_start every 50 ticks, src_manual=0 each time. auto_en=0 -> no further starts.
- Arbitration and coalescing: req_manual pulsed 3 times during GAP, plus auto expiry in the same window -> exactly one manual start at gap end, followed by one auto start 20 ticks later; no third start.
- Simultaneous meas_done with timeout tick (meas_dist=77) -> dist_out=77, dist_valid=1, timeout_err=0.
- Async reset: drive rst=0 mid-MEASURE, asynchronous to clk -> all outputs 0 immediately. After release with no requests, no sr04_start for 100 ticks.

Source files
------------

// File: rtl/sr04_meas_scheduler.sv
// sr04_meas_scheduler
// Shares the SR04 measurement path between a manual one-shot request and a
// periodic auto-ranging timer. It issues one-clk start pulses, keeps the
// sensor's minimum re-trigger gap, supervises each measurement with a
// timeout, and publishes the distance or flags a timeout error.
//
// Ports
//   clk_i          system clock (100 MHz)
//   rst_ni         asynchronous reset, active low
//   tick_1us_i     one-clk pulse every 1 us
//   req_manual_i   one-clk manual request pulse
//   auto_en_i      level, enables periodic requests
//   meas_done_i    one-clk pulse, echo measurement complete
//   meas_dist_i    distance in cm, valid with meas_done_i
//   sr04_start_o   one-clk start pulse to the SR04 controller
//   dist_out_o     last successful distance in cm
//   dist_valid_o   one-clk pulse when dist_out_o updates
//   timeout_err_o  sticky timeout flag, cleared by next good measurement
//   src_manual_o   requester of current/last measurement (1=manual, 0=auto)
//   busy_o         high in every state except IDLE
//
// state   | meaning
// IDLE    | waiting for a pending request; manual wins over auto
// ISSUE   | start pulse on the output, us counter cleared
// MEASURE | waiting for meas_done or the timeout tick
// GAP     | holding off until MIN_GAP_US after the start pulse
module sr04_meas_scheduler #(
  parameter int unsigned MIN_GAP_US     = 60000,
  parameter int unsigned TIMEOUT_US     = 30000,
  parameter int unsigned AUTO_PERIOD_US = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_1us_i,
  input  logic       req_manual_i,
  input  logic       auto_en_i,
  input  logic       meas_done_i,
  input  logic [8:0] meas_dist_i,
  output logic       sr04_start_o,
  output logic [8:0] dist_out_o,
  output logic       dist_valid_o,
  output logic       timeout_err_o,
  output logic       src_manual_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, MEASURE, GAP} state_e;

  localparam logic [16:0] CNT_MAX   = '1;
  localparam logic [16:0] TO_LAST   = 17'(TIMEOUT_US - 1);
  localparam logic [16:0] GAP_LAST  = 17'(MIN_GAP_US - 1);
  localparam logic [16:0] AUTO_LAST = 17'(AUTO_PERIOD_US - 1);

  state_e      state_q, state_d;
  logic [16:0] us_cnt_q, us_cnt_d;
  logic [16:0] auto_cnt_q, auto_cnt_d;
  logic        man_pend_q, man_pend_d;
  logic        auto_pend_q, auto_pend_d;
  logic        start_q, start_d;
  logic [8:0]  dist_q, dist_d;
  logic        valid_q, valid_d;
  logic        terr_q, terr_d;
  logic        src_q, src_d;
  logic        serve_man, serve_auto;
  logic        auto_wrap;
  logic [16:0] us_inc;

  // Counter saturates instead of wrapping.
  assign us_inc = (us_cnt_q == CNT_MAX) ? us_cnt_q : us_cnt_q + 17'd1;

  always_comb begin
    state_d    = state_q;
    us_cnt_d   = us_cnt_q;
    start_d    = 1'b0;
    valid_d    = 1'b0;
    dist_d     = dist_q;
    terr_d     = terr_q;
    src_d      = src_q;
    serve_man  = 1'b0;
    serve_auto = 1'b0;
    case (state_q)
      IDLE: begin
        if (man_pend_q) begin
          serve_man = 1'b1;
          src_d     = 1'b1;
          start_d   = 1'b1;
          state_d   = ISSUE;
        end else if (auto_pend_q) begin
          serve_auto = 1'b1;
          src_d      = 1'b0;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        us_cnt_d = '0;
        state_d  = MEASURE;
      end
      MEASURE: begin
        if (tick_1us_i) us_cnt_d = us_inc;
        // A completed echo beats a timeout tick in the same cycle.
        if (meas_done_i) begin
          dist_d  = meas_dist_i;
          valid_d = 1'b1;
          terr_d  = 1'b0;
          state_d = GAP;
        end else if (tick_1us_i && us_cnt_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick_1us_i) us_cnt_d = us_inc;
        if (tick_1us_i && us_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request flags: a new request in the same cycle as service is kept.
  always_comb begin
    auto_wrap = auto_en_i && tick_1us_i && (auto_cnt_q == AUTO_LAST);
    auto_cnt_d = auto_cnt_q;
    if (!auto_en_i)      auto_cnt_d = '0;
    else if (tick_1us_i) auto_cnt_d = auto_wrap ? 17'd0 : auto_cnt_q + 17'd1;
    man_pend_d  = req_manual_i | (man_pend_q & ~serve_man);
    auto_pend_d = auto_en_i & (auto_wrap | (auto_pend_q & ~serve_auto));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      us_cnt_q    <= '0;
      auto_cnt_q  <= '0;
      man_pend_q  <= 1'b0;
      auto_pend_q <= 1'b0;
      start_q     <= 1'b0;
      dist_q      <= '0;
      valid_q     <= 1'b0;
      terr_q      <= 1'b0;
      src_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      us_cnt_q    <= us_cnt_d;
      auto_cnt_q  <= auto_cnt_d;
      man_pend_q  <= man_pend_d;
      auto_pend_q <= auto_pend_d;
      start_q     <= start_d;
      dist_q      <= dist_d;
      valid_q     <= valid_d;
      terr_q      <= terr_d;
      src_q       <= src_d;
    end
  end

  assign sr04_start_o  = start_q;
  assign dist_out_o    = dist_q;
  assign dist_valid_o  = valid_q;
  assign timeout_err_o = terr_q;
  assign src_manual_o  = src_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_sr04_meas_scheduler.sv
module tb_sr04_meas_scheduler;

  localparam int GAP = 20;
  localparam int TO  = 10;
  localparam int AP  = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1us;
  logic       req_manual;
  logic       auto_en;
  logic       meas_done;
  logic [8:0] meas_dist;
  logic       sr04_start_o;
  logic [8:0] dist_out_o;
  logic       dist_valid_o;
  logic       timeout_err_o;
  logic       src_manual_o;
  logic       busy_o;

  sr04_meas_scheduler #(
    .MIN_GAP_US    (GAP),
    .TIMEOUT_US    (TO),
    .AUTO_PERIOD_US(AP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tick_1us_i   (tick_1us),
    .req_manual_i (req_manual),
    .auto_en_i    (auto_en),
    .meas_done_i  (meas_done),
    .meas_dist_i  (meas_dist),
    .sr04_start_o (sr04_start_o),
    .dist_out_o   (dist_out_o),
    .dist_valid_o (dist_valid_o),
    .timeout_err_o(timeout_err_o),
    .src_manual_o (src_manual_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_valid  = 0;
  bit src_log[$];
  bit cmp_en   = 1'b0;
  bit resp_en  = 1'b0;
  int resp_delay = 5;
  logic [8:0] resp_dist = 9'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // tick every 4 clk, changed just after the rising edge
  initial begin
    int tcnt = 0;
    tick_1us = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tick_1us = (tcnt % 4 == 0);
    end
  end

  // Returns at the falling edge just before the n-th upcoming tick edge.
  task automatic tick_edges(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (tick_1us) k++;
    end
  endtask

  task automatic wait_start(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sr04_start_o !== 1'b1 && k < bound);
    chk("wait_start", int'(sr04_start_o === 1'b1), 1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy_o !== 1'b0 && k < bound);
    chk("wait_idle", int'(busy_o === 1'b0), 1);
  endtask

  task automatic pulse_req();
    req_manual = 1'b1;
    @(negedge clk);
    req_manual = 1'b0;
  endtask

  // SR04 controller stand-in: answers each start after resp_delay ticks.
  initial begin
    meas_done = 1'b0;
    meas_dist = 9'd0;
    forever begin
      @(negedge clk);
      if (sr04_start_o === 1'b1 && resp_en) begin
        tick_edges(resp_delay);
        meas_done = 1'b1;
        meas_dist = resp_dist;
        @(negedge clk);
        meas_done = 1'b0;
        meas_dist = 9'd300;
      end
    end
  end

  always @(negedge clk) begin
    if (sr04_start_o === 1'b1) begin
      n_start++;
      src_log.push_back(src_manual_o);
    end
    if (dist_valid_o === 1'b1) n_valid++;
  end

  // Reference model in terms of elapsed ticks since each start pulse.
  bit         m_man = 0, m_auto = 0, m_busy = 0, m_issue = 0, m_resolved = 0;
  int         m_auto_ticks = 0, m_ticks = 0;
  bit         e_start = 0, e_valid = 0, e_terr = 0, e_src = 0;
  logic [8:0] e_dist = 9'd0;

  always @(posedge clk or negedge rst_n) begin : model
    bit serve_m, serve_a, expire;
    if (!rst_n) begin
      m_man = 0; m_auto = 0; m_busy = 0; m_issue = 0; m_resolved = 0;
      m_auto_ticks = 0; m_ticks = 0;
      e_start = 0; e_valid = 0; e_terr = 0; e_src = 0; e_dist = 9'd0;
    end else begin
      serve_m = 0;
      serve_a = 0;
      expire  = 0;
      e_start = 0;
      e_valid = 0;
      if (!m_busy) begin
        if (m_man) serve_m = 1;
        else if (m_auto) serve_a = 1;
        if (serve_m || serve_a) begin
          m_busy = 1; m_issue = 1; e_start = 1; e_src = serve_m;
        end
      end else if (m_issue) begin
        m_issue = 0; m_ticks = 0; m_resolved = 0;
      end else if (!m_resolved) begin
        if (tick_1us) m_ticks++;
        if (meas_done) begin
          e_dist = meas_dist; e_valid = 1; e_terr = 0; m_resolved = 1;
        end else if (tick_1us && m_ticks == TO) begin
          e_terr = 1; m_resolved = 1;
        end
      end else if (tick_1us) begin
        m_ticks++;
        if (m_ticks == GAP) m_busy = 0;
      end
      if (!auto_en) m_auto_ticks = 0;
      else if (tick_1us) begin
        m_auto_ticks++;
        if (m_auto_ticks == AP) begin
          expire = 1;
          m_auto_ticks = 0;
        end
      end
      if (serve_m) m_man = 0;
      if (req_manual) m_man = 1;
      if (serve_a) m_auto = 0;
      if (expire) m_auto = 1;
      if (!auto_en) m_auto = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_start", int'(sr04_start_o), int'(e_start));
      chk("cyc_dist",  int'(dist_out_o),   int'(e_dist));
      chk("cyc_valid", int'(dist_valid_o), int'(e_valid));
      chk("cyc_terr",  int'(timeout_err_o), int'(e_terr));
      chk("cyc_src",   int'(src_manual_o), int'(e_src));
      chk("cyc_busy",  int'(busy_o),       int'(m_busy));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s, base_v, base_q;
    rst_n = 1'b0; req_manual = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", int'(sr04_start_o), 0);
    chk("rst_dist",  int'(dist_out_o), 0);
    chk("rst_valid", int'(dist_valid_o), 0);
    chk("rst_terr",  int'(timeout_err_o), 0);
    chk("rst_src",   int'(src_manual_o), 0);
    chk("rst_busy",  int'(busy_o), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);

    // manual single shot
    resp_en = 1; resp_delay = 5; resp_dist = 9'd123;
    base_v = n_valid;
    pulse_req();
    chk("lat_1clk", int'(sr04_start_o), 0);
    @(negedge clk);
    chk("lat_2clk", int'(sr04_start_o), 1);
    tick_edges(20);
    chk("gap_busy_19", int'(busy_o), 1);
    @(negedge clk);
    chk("gap_busy_20", int'(busy_o), 0);
    chk("a_dist", int'(dist_out_o), 123);
    chk("a_src", int'(src_manual_o), 1);
    chk("a_nvalid", n_valid - base_v, 1);
    chk("a_terr", int'(timeout_err_o), 0);

    // timeout, then recovery
    resp_en = 0;
    base_v = n_valid;
    pulse_req();
    wait_start(20);
    tick_edges(10);
    chk("to_terr_pre", int'(timeout_err_o), 0);
    @(negedge clk);
    chk("to_terr_at10", int'(timeout_err_o), 1);
    wait_idle(400);
    chk("to_dist_hold", int'(dist_out_o), 123);
    chk("to_nvalid", n_valid - base_v, 0);
    resp_en = 1; resp_delay = 2; resp_dist = 9'd42;
    pulse_req();
    wait_start(20);
    wait_idle(400);
    chk("rec_terr", int'(timeout_err_o), 0);
    chk("rec_dist", int'(dist_out_o), 42);

    // auto period
    resp_delay = 3; resp_dist = 9'd200;
    base_s = n_start;
    base_q = src_log.size();
    auto_en = 1;
    tick_edges(210);
    auto_en = 0;
    wait_idle(400);
    chk("auto_nstart", n_start - base_s, 4);
    begin
      int any_man = 0;
      for (int i = base_q; i < src_log.size(); i++) any_man |= int'(src_log[i]);
      chk("auto_src", any_man, 0);
    end
    base_s = n_start;
    tick_edges(150);
    chk("auto_off", n_start - base_s, 0);

    // arbitration and coalescing
    resp_delay = 3; resp_dist = 9'd88;
    auto_en = 1;
    tick_edges(35);
    pulse_req();
    wait_start(20);
    @(negedge clk);
    base_s = n_start;
    base_q = src_log.size();
    tick_edges(5);  pulse_req();
    tick_edges(3);  pulse_req();
    tick_edges(3);  pulse_req();
    wait_start(400);
    wait_start(400);
    auto_en = 0;
    wait_idle(400);
    tick_edges(60);
    chk("arb_nstart", n_start - base_s, 2);
    if (src_log.size() >= base_q + 2) begin
      chk("arb_src_first", int'(src_log[base_q]), 1);
      chk("arb_src_second", int'(src_log[base_q + 1]), 0);
    end

    // meas_done coincident with the timeout tick
    resp_en = 0;
    pulse_req();
    wait_start(20);
    wait_idle(400);
    chk("sim_pre_terr", int'(timeout_err_o), 1);
    resp_en = 1; resp_delay = 10; resp_dist = 9'd77;
    base_v = n_valid;
    pulse_req();
    wait_start(20);
    wait_idle(400);
    chk("sim_dist", int'(dist_out_o), 77);
    chk("sim_terr", int'(timeout_err_o), 0);
    chk("sim_nvalid", n_valid - base_v, 1);

    // asynchronous reset mid-measurement
    resp_delay = 10; resp_dist = 9'd55;
    pulse_req();
    wait_start(20);
    tick_edges(4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_start", int'(sr04_start_o), 0);
    chk("arst_dist",  int'(dist_out_o), 0);
    chk("arst_valid", int'(dist_valid_o), 0);
    chk("arst_terr",  int'(timeout_err_o), 0);
    chk("arst_src",   int'(src_manual_o), 0);
    chk("arst_busy",  int'(busy_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base_s = n_start;
    base_v = n_valid;
    tick_edges(100);
    chk("post_rst_nstart", n_start - base_s, 0);
    chk("post_rst_nvalid", n_valid - base_v, 0);
    chk("post_rst_busy", int'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
